centroid_tracker: RTL and testbench
===================================

Name: centroid_tracker

Overview:
Accumulates a per-pixel binary detection mask over one video frame and produces the blob centroid, bounding box and pixel count consumed by the overlay stage. Sits between the colour-threshold/mask stage and overlay_manager, and runs on the same pixel clock and draw_x/draw_y/vde timing. Results are computed once per frame by a sequential divider and held stable for the whole next frame.

Parameters:
FRAME_WIDTH, 640, active pixels per line; last pixel is x = FRAME_WIDTH-1
FRAME_HEIGHT, 480, active lines per frame; last line is y = FRAME_HEIGHT-1
MIN_PIXELS, 16, minimum mask count for centroid_valid = 1

Ports:
clk  in  1  pixel clock; the block's only clock
rst  in  1  synchronous, active-high reset
enable  in  1  accumulation enable, sampled per pixel
draw_x  in  10  current pixel column
draw_y  in  10  current pixel row
vde  in  1  active video
mask_in  in  1  1 = pixel belongs to the tracked blob
centroid_x  out  10  floor(sum_x / count)
centroid_y  out  10  floor(sum_y / count)
centroid_valid  out  1  count >= MIN_PIXELS for the last published frame
bbox_min_x / bbox_min_y / bbox_max_x / bbox_max_y  out  10 each  bounding box of masked pixels
pixel_count  out  19  masked pixel count of the last published frame
frame_update  out  1  one-cycle pulse when outputs change
busy  out  1  high while the divider FSM is not in ACCUM

Behaviour:
- Reset: all outputs are 0, accumulators are cleared, min_x/min_y are 1023, max_x/max_y are 0, and the FSM is in ACCUM. Reset takes effect in any state, including mid-divide, with no partial publish.
- Accumulation, every cycle: if vde && enable && mask_in, then count += 1, sum_x += draw_x, sum_y += draw_y, and the min/max registers are updated.
  - Widths: count is 19 bits; sum_x and sum_y are 28 bits each. Overflow is impossible within the frame size.
- Frame end: the cycle T in which vde && draw_x == FRAME_WIDTH-1 && draw_y == FRAME_HEIGHT-1.
  - The pixel at T is included in the frame.
  - At T+1 the totals are copied to snapshot registers and the accumulators are cleared. Pixels arriving at T+1 and later belong to the next frame.
  - The frame-end pixel is recognised even when enable = 0; the frame is then published with count 0.
- FSM states: ACCUM -> DIV_X -> DIV_Y -> PUBLISH -> ACCUM.
  - ACCUM: waits for frame end.
  - DIV_X: restoring division, 10 cycles, one quotient bit per cycle, MSB first. It computes floor(snap_sum_x / snap_count); a 10-bit quotient is sufficient because sum < count*1024.
  - DIV_Y: same as DIV_X for snap_sum_y.
  - PUBLISH: 1 cycle; loads the output registers.
- Latency: outputs change and frame_update = 1 in cycle T+22. busy is high from T+1 through T+21.
- Division is skipped when snap_count == 0: the divider still runs its cycles (fixed latency) but the quotients are forced to 0.
- Publish rules:
  - If count >= MIN_PIXELS: centroid_valid = 1 and the bbox is loaded from the snapshot.
  - Otherwise: centroid_valid = 0; centroid, bbox and pixel_count are still loaded (bbox = 0 when count == 0).
- Frame end seen while busy (impossible at nominal blanking): that frame's data is dropped, the accumulators are cleared, and the in-flight divide completes unaffected.
- Mask pixels while vde = 0 are ignored. Outputs are stable between frame_update pulses.

Test Plan:
- Single masked pixel at (100,50), MIN_PIXELS = 1 -> centroid (100,50), bbox 100/50/100/50, count 1, valid 1, frame_update exactly at T+22.
- 10x10 square (200..209, 100..109) -> centroid (204,104) by floor, bbox 200/100/209/109, count 100, valid 1.
- Two pixels (0,0) and (639,479), MIN_PIXELS = 1 -> centroid (319,239), bbox 0/0/639/479; the frame-end pixel is counted.
- 15 masked pixels, MIN_PIXELS = 16 -> valid 0, count 15. Empty frame -> valid 0, all coordinates 0. enable = 0 over a full mask -> count 0, valid 0, frame_update still pulses.
- Assert rst at T+8 (mid DIV_X) -> all outputs 0 next cycle, no frame_update pulse, and the next frame publishes correctly.
- Back-to-back frames with different blobs (A then B) -> outputs hold A's values until B's T+22, then switch; the accumulators show no carry-over from A.

Source files
------------

// File: rtl/centroid_tracker.sv
// centroid_tracker: per-frame blob centroid, bounding box and pixel count from a binary mask
module centroid_tracker #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int MIN_PIXELS   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic        vde,
  input  logic        mask_in,
  output logic [9:0]  centroid_x,
  output logic [9:0]  centroid_y,
  output logic        centroid_valid,
  output logic [9:0]  bbox_min_x,
  output logic [9:0]  bbox_min_y,
  output logic [9:0]  bbox_max_x,
  output logic [9:0]  bbox_max_y,
  output logic [18:0] pixel_count,
  output logic        frame_update,
  output logic        busy
);
  typedef enum logic [1:0] {ACCUM, DIV_X, DIV_Y, PUBLISH} state_t;
  state_t state;
  logic [18:0] count, snap_count, nx_count;
  logic [27:0] sum_x, sum_y, snap_sum_x, snap_sum_y, nx_sum_x, nx_sum_y, rem, shifted;
  logic [9:0]  min_x, min_y, max_x, max_y, nx_min_x, nx_min_y, nx_max_x, nx_max_y;
  logic [9:0]  snap_min_x, snap_min_y, snap_max_x, snap_max_y, qx, qy;
  logic [3:0]  bit_i;
  logic        hit, fe, ge, empty;
  always_comb begin
    hit      = vde && enable && mask_in;
    fe       = vde && draw_x == 10'(FRAME_WIDTH - 1) && draw_y == 10'(FRAME_HEIGHT - 1);
    nx_count = count + 19'(hit);
    nx_sum_x = sum_x + (hit ? 28'(draw_x) : 28'd0);
    nx_sum_y = sum_y + (hit ? 28'(draw_y) : 28'd0);
    nx_min_x = hit && draw_x < min_x ? draw_x : min_x;
    nx_min_y = hit && draw_y < min_y ? draw_y : min_y;
    nx_max_x = hit && draw_x > max_x ? draw_x : max_x;
    nx_max_y = hit && draw_y > max_y ? draw_y : max_y;
    empty    = snap_count == 19'd0;
    shifted  = {9'd0, snap_count} << bit_i;
    ge       = !empty && rem >= shifted;
    busy     = state != ACCUM;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      {count, sum_x, sum_y, max_x, max_y} <= '0;
      {min_x, min_y} <= '1;
      {snap_count, snap_sum_x, snap_sum_y, snap_min_x, snap_min_y, snap_max_x, snap_max_y} <= '0;
      {rem, bit_i, qx, qy} <= '0;
      {centroid_x, centroid_y, centroid_valid, pixel_count, frame_update} <= '0;
      {bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y} <= '0;
    end else begin
      frame_update <= 1'b0;
      // a frame end always restarts accumulation, even if the divider is still busy
      count <= fe ? '0 : nx_count;
      sum_x <= fe ? '0 : nx_sum_x;
      sum_y <= fe ? '0 : nx_sum_y;
      min_x <= fe ? '1 : nx_min_x;
      min_y <= fe ? '1 : nx_min_y;
      max_x <= fe ? '0 : nx_max_x;
      max_y <= fe ? '0 : nx_max_y;
      case (state)
        ACCUM: if (fe) begin
          snap_count <= nx_count;
          snap_sum_x <= nx_sum_x;
          snap_sum_y <= nx_sum_y;
          snap_min_x <= nx_min_x;
          snap_min_y <= nx_min_y;
          snap_max_x <= nx_max_x;
          snap_max_y <= nx_max_y;
          rem        <= nx_sum_x;
          bit_i      <= 4'd9;
          state      <= DIV_X;
        end
        DIV_X, DIV_Y: begin
          if (state == DIV_X) qx[bit_i] <= ge;
          else qy[bit_i] <= ge;
          rem   <= state == DIV_X && bit_i == 4'd0 ? snap_sum_y : ge ? rem - shifted : rem;
          bit_i <= bit_i == 4'd0 ? 4'd9 : bit_i - 4'd1;
          if (bit_i == 4'd0) state <= state == DIV_X ? DIV_Y : PUBLISH;
        end
        default: begin
          centroid_x     <= qx;
          centroid_y     <= qy;
          pixel_count    <= snap_count;
          centroid_valid <= snap_count >= 19'(MIN_PIXELS);
          bbox_min_x     <= empty ? '0 : snap_min_x;
          bbox_min_y     <= empty ? '0 : snap_min_y;
          bbox_max_x     <= empty ? '0 : snap_max_x;
          bbox_max_y     <= empty ? '0 : snap_max_y;
          frame_update   <= 1'b1;
          state          <= ACCUM;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_centroid_tracker.sv
// tb_centroid_tracker: randomized frames checked against an array-based frame model
module tb_centroid_tracker;
  localparam int W = 32, H = 16, HB = 4, VB = 3, MINP = 16;
  logic clk = 0, rst = 1, enable = 0, vde = 0, mask_in = 0;
  logic [9:0] draw_x = 0, draw_y = 0;
  logic [9:0] centroid_x, centroid_y, bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y;
  logic [18:0] pixel_count;
  logic centroid_valid, frame_update, busy;
  bit msk [H][W];
  int e[8], cur[8], zero[8];
  int cyc = 0, fu_cnt = 0, fu_cyc = 0, busy_cnt = 0, n_chk = 0, n_pass = 0;

  centroid_tracker #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .MIN_PIXELS(MINP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .draw_x(draw_x), .draw_y(draw_y), .vde(vde),
    .mask_in(mask_in), .centroid_x(centroid_x), .centroid_y(centroid_y),
    .centroid_valid(centroid_valid), .bbox_min_x(bbox_min_x), .bbox_min_y(bbox_min_y),
    .bbox_max_x(bbox_max_x), .bbox_max_y(bbox_max_y), .pixel_count(pixel_count),
    .frame_update(frame_update), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (frame_update) begin fu_cnt++; fu_cyc = cyc; end
    if (busy) busy_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic chk_out(input string p, input int x[8]);
    chk({p, ".cx"}, centroid_x, x[0]);
    chk({p, ".cy"}, centroid_y, x[1]);
    chk({p, ".cnt"}, pixel_count, x[2]);
    chk({p, ".valid"}, centroid_valid, x[3]);
    chk({p, ".minx"}, bbox_min_x, x[4]);
    chk({p, ".miny"}, bbox_min_y, x[5]);
    chk({p, ".maxx"}, bbox_max_x, x[6]);
    chk({p, ".maxy"}, bbox_max_y, x[7]);
  endtask

  task automatic model(input bit en);
    int n = 0, sx = 0, sy = 0, mnx = W, mny = H, mxx = 0, mxy = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (en && msk[y][x]) begin
          n++; sx += x; sy += y;
          if (x < mnx) mnx = x;
          if (y < mny) mny = y;
          if (x > mxx) mxx = x;
          if (y > mxy) mxy = y;
        end
    e = '{default: 0};
    e[2] = n;
    e[3] = int'(n >= MINP);
    if (n > 0) begin
      e[0] = sx / n; e[1] = sy / n;
      e[4] = mnx; e[5] = mny; e[6] = mxx; e[7] = mxy;
    end
  endtask

  task automatic clear_mask();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) msk[y][x] = 0;
  endtask

  task automatic run_frame(input string tag, input bit en, input int rst_at);
    int fe_cyc = 0;
    int fu0 = fu_cnt, b0 = busy_cnt;
    model(en);
    for (int y = 0; y < H + VB; y++)
      for (int x = 0; x < W + HB; x++) begin
        @(negedge clk);
        if (fe_cyc == 0 && y == H - 1 && x == W - 1) begin
          fe_cyc = cyc + 1;
          chk({tag, ".hold_cx"}, centroid_x, cur[0]);
          chk({tag, ".hold_cnt"}, pixel_count, cur[2]);
          chk({tag, ".hold_valid"}, centroid_valid, cur[3]);
        end
        vde = x < W && y < H;
        draw_x = 10'(x);
        draw_y = 10'(y);
        enable = en;
        mask_in = vde ? msk[y][x] : 1'($urandom);
        rst = rst_at >= 0 && fe_cyc != 0 && cyc + 1 - fe_cyc == rst_at;
      end
    @(negedge clk);
    vde = 0;
    rst = 0;
    if (rst_at >= 0) begin
      e = '{default: 0};
      chk({tag, ".fu_pulses"}, fu_cnt - fu0, 0);
      chk({tag, ".busy_len"}, busy_cnt - b0, rst_at);
    end else begin
      chk({tag, ".fu_pulses"}, fu_cnt - fu0, 1);
      chk({tag, ".fu_lat"}, fu_cyc - fe_cyc, 21);
      chk({tag, ".busy_len"}, busy_cnt - b0, 21);
    end
    chk_out(tag, e);
    cur = e;
  endtask

  task automatic rand_blob();
    int x0 = $urandom_range(0, W - 1), y0 = $urandom_range(0, H - 1);
    int x1 = $urandom_range(x0, W - 1), y1 = $urandom_range(y0, H - 1);
    clear_mask();
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) msk[y][x] = $urandom_range(0, 3) != 0;
  endtask

  initial begin
    zero = '{default: 0};
    cur = zero;
    repeat (3) @(negedge clk);
    chk_out("reset", zero);
    chk("reset.busy", busy, 0);
    chk("reset.fu", frame_update, 0);
    rst = 0;
    clear_mask(); msk[5][10] = 1;
    run_frame("single", 1, -1);
    clear_mask();
    for (int y = 3; y < 13; y++)
      for (int x = 5; x < 15; x++) msk[y][x] = 1;
    run_frame("square", 1, -1);
    clear_mask(); msk[0][0] = 1; msk[H-1][W-1] = 1;
    run_frame("corners", 1, -1);
    clear_mask();
    for (int i = 0; i < 15; i++) msk[$urandom_range(0, H - 1)][2 * i] = 1;
    run_frame("fifteen", 1, -1);
    clear_mask();
    run_frame("empty", 1, -1);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) msk[y][x] = 1;
    run_frame("full_en0", 0, -1);
    rand_blob();
    run_frame("blob_a", 1, -1);
    rand_blob();
    run_frame("rst_mid_div", 1, 8);
    for (int k = 0; k < 6; k++) begin
      rand_blob();
      run_frame($sformatf("rand%0d", k), 1, -1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
